// File: rtl/morph_program_sequencer_if.sv
// Bundle between the genetic engine, the program sequencer and the morphologic processor.
// The master modport is the sequencer; the slave modport is its environment.
interface morph_program_sequencer_if #(
    parameter int ImageWidth   = 8,
    parameter int ImageHeight  = 4,
    parameter int InstrCount   = 4,
    parameter int CounterWidth = 3
);
    logic                               start;
    logic [16*InstrCount-1:0]           prog;
    logic [CounterWidth-1:0]            progLen;
    logic [ImageWidth*ImageHeight-1:0]  imageAcc;
    logic                               procRst;
    logic                               procCe;
    logic [8:0]                         el;
    logic [2:0]                         morphOp;
    logic                               morphInSelect;
    logic [2:0]                         logicOp;
    logic [CounterWidth-1:0]            instrIndex;
    logic                               busy;
    logic                               done;
    logic [ImageWidth*ImageHeight-1:0]  result;

    modport master (
        input  start, prog, progLen, imageAcc,
        output procRst, procCe, el, morphOp, morphInSelect, logicOp,
               instrIndex, busy, done, result
    );

    modport slave (
        output start, prog, progLen, imageAcc,
        input  procRst, procCe, el, morphOp, morphInSelect, logicOp,
               instrIndex, busy, done, result
    );
endinterface

// File: rtl/morph_program_sequencer.sv
// Plays a latched chromosome into the morphologic processor one instruction per clock,
// then captures the processor's accumulator image as the result.
module morph_program_sequencer #(
    parameter int ImageWidth   = 8,
    parameter int ImageHeight  = 4,
    parameter int InstrCount   = 4,
    parameter int CounterWidth = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    morph_program_sequencer_if.master  bus
);
    localparam int ResultW = ImageWidth * ImageHeight;
    localparam int IdxW    = (InstrCount > 1) ? $clog2(InstrCount) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        CAPTURE,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CounterWidth-1:0] index;
    logic [CounterWidth-1:0] index_next;
    logic [CounterWidth-1:0] len;
    logic [15:0]             instr_mem [InstrCount];
    logic [15:0]             instr;
    logic [ResultW-1:0]      result_q;
    logic                    last_instr;

    function automatic logic [CounterWidth-1:0] clamp_len(input logic [CounterWidth-1:0] l);
        if (int'(l) > InstrCount) begin
            return CounterWidth'(InstrCount);
        end
        return l;
    endfunction

    // Program and length are data: captured on the accepting edge, no reset needed.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            len <= clamp_len(bus.progLen);
            for (int i = 0; i < InstrCount; i++) begin
                instr_mem[i] <= bus.prog[16*i +: 16];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            index <= '0;
        end else begin
            state <= state_next;
            index <= index_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q <= '0;
        end else if (state == CAPTURE) begin
            result_q <= bus.imageAcc;
        end
    end

    assign last_instr = (index == len - CounterWidth'(1));
    assign instr      = instr_mem[index[IdxW-1:0]];

    // Index only advances inside RUN; every other state parks it at zero.
    always_comb begin
        state_next = state;
        index_next = '0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                state_next = (len != '0) ? RUN : CAPTURE;
            end
            RUN: begin
                if (last_instr) begin
                    state_next = CAPTURE;
                end else begin
                    index_next = index + CounterWidth'(1);
                end
            end
            CAPTURE: begin
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Processor reset follows the block reset directly so it holds while rst is low.
    always_comb begin
        bus.procRst       = ~rst | (state == CLEAR);
        bus.procCe        = 1'b0;
        bus.el            = '0;
        bus.morphOp       = '0;
        bus.morphInSelect = 1'b0;
        bus.logicOp       = '0;
        if (state == RUN) begin
            bus.procCe        = 1'b1;
            bus.el            = instr[15:7];
            bus.morphOp       = instr[6:4];
            bus.morphInSelect = instr[3];
            bus.logicOp       = instr[2:0];
        end
    end

    assign bus.instrIndex = index;
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);
    assign bus.result     = result_q;

endmodule

// File: tb/tb_morph_program_sequencer.sv
// Directed bench for morph_program_sequencer: reset, short/empty/clamped programs,
// interference during a run, and reset mid-run.
module tb_morph_program_sequencer;
    localparam int ImageWidth   = 8;
    localparam int ImageHeight  = 4;
    localparam int InstrCount   = 4;
    localparam int CounterWidth = 3;

    logic clk;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    morph_program_sequencer_if #(
        .ImageWidth(ImageWidth), .ImageHeight(ImageHeight),
        .InstrCount(InstrCount), .CounterWidth(CounterWidth)
    ) bus ();

    morph_program_sequencer #(
        .ImageWidth(ImageWidth), .ImageHeight(ImageHeight),
        .InstrCount(InstrCount), .CounterWidth(CounterWidth)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_instr(input string tag, input int idx, input logic [15:0] w);
        chk({tag, ".ce"},    64'(bus.procCe), 64'd1);
        chk({tag, ".rstp"},  64'(bus.procRst), 64'd0);
        chk({tag, ".idx"},   64'(bus.instrIndex), 64'(idx));
        chk({tag, ".el"},    64'(bus.el), 64'(w[15:7]));
        chk({tag, ".mop"},   64'(bus.morphOp), 64'(w[6:4]));
        chk({tag, ".sel"},   64'(bus.morphInSelect), 64'(w[3]));
        chk({tag, ".lop"},   64'(bus.logicOp), 64'(w[2:0]));
        chk({tag, ".done"},  64'(bus.done), 64'd0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".ce"},  64'(bus.procCe), 64'd0);
        chk({tag, ".el"},  64'(bus.el), 64'd0);
        chk({tag, ".mop"}, 64'(bus.morphOp), 64'd0);
        chk({tag, ".sel"}, 64'(bus.morphInSelect), 64'd0);
        chk({tag, ".lop"}, 64'(bus.logicOp), 64'd0);
    endtask

    logic [15:0] w4 [4];
    logic [15:0] w3 [3];

    initial begin
        w4[0] = 16'hFF81; w4[1] = 16'h0042; w4[2] = 16'h8033; w4[3] = 16'h00FC;
        w3[0] = 16'h8011; w3[1] = 16'h4022; w3[2] = 16'h2033;

        // Reset held with start high
        rst          = 1'b0;
        bus.start    = 1'b1;
        bus.prog     = {16'h1111, 16'h2222, 16'h0418, 16'h5D28};
        bus.progLen  = 3'd2;
        bus.imageAcc = 32'hCAFE_F00D;
        #1;
        chk("rst0.procRst", 64'(bus.procRst), 64'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst.procRst", 64'(bus.procRst), 64'd1);
            chk("rst.busy",    64'(bus.busy), 64'd0);
            chk("rst.done",    64'(bus.done), 64'd0);
            chk("rst.result",  64'(bus.result), 64'd0);
            chk("rst.idx",     64'(bus.instrIndex), 64'd0);
            chk_quiet("rst");
        end
        bus.start = 1'b0;
        rst       = 1'b1;
        tick();
        tick();
        chk("postrst.busy",    64'(bus.busy), 64'd0);
        chk("postrst.procRst", 64'(bus.procRst), 64'd0);

        // Two-instruction run
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("two.clear.procRst", 64'(bus.procRst), 64'd1);
        chk("two.clear.busy",    64'(bus.busy), 64'd1);
        chk_quiet("two.clear");
        tick();
        chk_instr("two.i0", 0, 16'h5D28);
        chk("two.i0.el_lit", 64'(bus.el), 64'(9'b010111010));
        tick();
        chk_instr("two.i1", 1, 16'h0418);
        chk("two.i1.el_lit", 64'(bus.el), 64'(9'b000001000));
        bus.imageAcc = 32'hDEAD_BEEF;
        tick();
        chk_quiet("two.cap");
        chk("two.cap.done", 64'(bus.done), 64'd0);
        tick();
        chk("two.done",   64'(bus.done), 64'd1);
        chk("two.result", 64'(bus.result), 64'hDEAD_BEEF);
        chk("two.busy",   64'(bus.busy), 64'd1);
        tick();
        chk("two.after.done", 64'(bus.done), 64'd0);
        chk("two.after.busy", 64'(bus.busy), 64'd0);

        // Empty program
        bus.progLen  = 3'd0;
        bus.imageAcc = 32'h0;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("empty.clear.procRst", 64'(bus.procRst), 64'd1);
        tick();
        chk_quiet("empty.cap");
        chk("empty.cap.done", 64'(bus.done), 64'd0);
        tick();
        chk("empty.done",   64'(bus.done), 64'd1);
        chk("empty.result", 64'(bus.result), 64'd0);
        tick();
        chk("empty.after.done", 64'(bus.done), 64'd0);

        // Length above InstrCount clamps to four
        bus.prog     = {w4[3], w4[2], w4[1], w4[0]};
        bus.progLen  = 3'd7;
        bus.imageAcc = 32'h0F0F_0F0F;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_instr("clamp", i, w4[i]);
        end
        tick();
        chk_quiet("clamp.cap");
        chk("clamp.cap.done", 64'(bus.done), 64'd0);
        tick();
        chk("clamp.done",   64'(bus.done), 64'd1);
        chk("clamp.result", 64'(bus.result), 64'h0F0F_0F0F);

        // Start re-asserted and program changed during the run
        tick();
        bus.prog     = {16'h0, w3[2], w3[1], w3[0]};
        bus.progLen  = 3'd3;
        bus.imageAcc = 32'h1357_9BDF;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk_instr("intf.i0", 0, w3[0]);
        bus.prog    = '1;
        bus.progLen = 3'd1;
        bus.start   = 1'b1;
        tick();
        chk_instr("intf.i1", 1, w3[1]);
        tick();
        chk_instr("intf.i2", 2, w3[2]);
        tick();
        chk_quiet("intf.cap");
        chk("intf.cap.done", 64'(bus.done), 64'd0);
        tick();
        chk("intf.done",   64'(bus.done), 64'd1);
        chk("intf.result", 64'(bus.result), 64'h1357_9BDF);
        bus.start = 1'b0;
        tick();
        chk("intf.after.done", 64'(bus.done), 64'd0);
        chk("intf.after.busy", 64'(bus.busy), 64'd0);
        tick();
        chk("intf.after2.done", 64'(bus.done), 64'd0);

        // Reset asserted mid-run at instrIndex 1
        bus.prog     = {16'h0, w3[2], w3[1], w3[0]};
        bus.progLen  = 3'd3;
        bus.imageAcc = 32'h2468_ACE0;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        chk_instr("mid.i1", 1, w3[1]);
        #2;
        rst = 1'b0;
        #1;
        chk("mid.procRst", 64'(bus.procRst), 64'd1);
        chk("mid.busy",    64'(bus.busy), 64'd0);
        chk("mid.idx",     64'(bus.instrIndex), 64'd0);
        chk("mid.result",  64'(bus.result), 64'd0);
        chk("mid.done",    64'(bus.done), 64'd0);
        chk_quiet("mid");
        tick();
        chk("mid.hold.done", 64'(bus.done), 64'd0);
        tick();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("mid.idle.done", 64'(bus.done), 64'd0);
            chk("mid.idle.busy", 64'(bus.busy), 64'd0);
        end

        // Full run after the abandoned one
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("re.clear.procRst", 64'(bus.procRst), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_instr("re", i, w3[i]);
        end
        tick();
        chk_quiet("re.cap");
        tick();
        chk("re.done",   64'(bus.done), 64'd1);
        chk("re.result", 64'(bus.result), 64'h2468_ACE0);
        tick();
        chk("re.after.done", 64'(bus.done), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
